// File: rtl/reg4_readback_pkg.sv
// Shared definitions for the reg4_readback serial read-out block.
// Optional feature macro: REG4_READBACK_PARITY_EN (adds an even-parity bit per register).
package reg4_readback_pkg;

    localparam int DATA_W = 4;

`ifdef REG4_READBACK_PARITY_EN
    localparam int BITS_PER_REG = DATA_W + 1;
`else
    localparam int BITS_PER_REG = DATA_W;
`endif

    // Wide enough to count up to the parity bit position.
    localparam int BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Even parity: XOR of all data bits, so data plus parity has an even number of ones.
    function automatic logic even_parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/reg4_readback_piso.sv
// 4-bit parallel-in / serial-out register, shifting right so bit 0 leaves first.
// Load has priority over shift; asynchronous active-low clear.
module reg4_piso
    import reg4_readback_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit0_o
);

    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;

    // Next contents: snapshot on load, otherwise move one place toward bit 0.
    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = data_i;
        end else if (shift_i) begin
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign bit0_o = shift_q[0];

endmodule

// File: rtl/reg4_readback.sv
// reg4_readback: reads one register (rd_req) or the whole bank (rd_all) and
// streams the bits LSB first over a valid/ready serial link.
// Optional feature macro: REG4_READBACK_PARITY_EN appends an even-parity bit
// after bit 3 of every register and moves ser_last onto that bit.
module reg4_readback
    import reg4_readback_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REGS*DATA_W-1:0] regs,
    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_all,
    output logic                       rd_busy,
    output logic                       rd_done,
    output logic                       rd_err,
    output logic                       ser_data,
    output logic                       ser_valid,
    input  logic                       ser_ready,
    output logic                       ser_last
);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic                 all_q, all_d;
    logic                 err_q, err_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0]    sel_data;
    logic                 sel_hit;
    logic                 piso_load;
    logic                 piso_shift;
    logic                 piso_bit;
    logic                 data_bit;
    logic                 xfer;
    logic                 last_bit;
    logic                 last_reg;

    // Register selected by the index counter; out-of-range indices read as zero.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx_q == ADDR_W'(k)) begin
                sel_data = regs[k*DATA_W +: DATA_W];
                sel_hit  = 1'b1;
            end
        end
    end

    assign xfer     = (state_q == SHIFT) && ser_ready;
    assign last_bit = (cnt_q == BIT_CNT_W'(BITS_PER_REG - 1));
    // A single read is always its own last register; rd_all ends at the top index.
    assign last_reg = !all_q || (idx_q == ADDR_W'(NUM_REGS - 1));

    reg4_piso u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (piso_load),
        .shift_i (piso_shift),
        .data_i  (sel_data),
        .bit0_o  (piso_bit)
    );

`ifdef REG4_READBACK_PARITY_EN
    logic par_q, par_d;

    // Parity is captured with the same snapshot as the data bits.
    always_comb begin
        par_d = par_q;
        if (piso_load) begin
            par_d = even_parity(sel_data);
        end
    end

    // Parity bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign data_bit = (cnt_q == BIT_CNT_W'(DATA_W)) ? par_q : piso_bit;
`else
    assign data_bit = piso_bit;
`endif

    // Next-state logic: request acceptance, per-register load, bit stepping, frame end.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        all_d      = all_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                // rd_all takes priority over a simultaneous rd_req.
                if (rd_all) begin
                    all_d   = 1'b1;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end else if (rd_req) begin
                    all_d   = 1'b0;
                    idx_d   = rd_addr;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                piso_load = 1'b1;
                cnt_d     = '0;
                if (!sel_hit) begin
                    err_d = 1'b1;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                if (xfer) begin
                    if (last_bit) begin
                        if (last_reg) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LOAD;
                        end
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        piso_shift = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and counter registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            all_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            all_q   <= all_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode directly from state, so they are stable while a bit is stalled.
    assign ser_valid = (state_q == SHIFT);
    assign ser_data  = ser_valid && data_bit;
    assign ser_last  = ser_valid && last_bit && last_reg;
    assign rd_busy   = (state_q != IDLE);
    assign rd_done   = (state_q == DONE);
    assign rd_err    = rd_done && err_q;

endmodule

// File: tb/tb_reg4_readback.sv
// Self-checking bench for reg4_readback. Uses a 5-register bank so that
// 3-bit addresses 5..7 exercise the out-of-range path.
`timescale 1ns/1ps
module tb_reg4_readback;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 3;
`ifdef REG4_READBACK_PARITY_EN
    localparam int BPR = 5;
    localparam logic [31:0] S1_BITS = 32'h0000000A;
    localparam logic [31:0] S2_BITS = {7'b0, 5'h05, 5'h14, 5'h03, 5'h12, 5'h11};
`else
    localparam int BPR = 4;
    localparam logic [31:0] S1_BITS = 32'h0000000A;
    localparam logic [31:0] S2_BITS = 32'h00054321;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_REGS*4-1:0]  regs = '0;
    logic                   rd_req = 1'b0;
    logic [ADDR_W-1:0]      rd_addr = '0;
    logic                   rd_all = 1'b0;
    logic                   ser_ready = 1'b0;
    logic                   rd_busy, rd_done, rd_err, ser_data, ser_valid, ser_last;

    always #5 clk = ~clk;

    reg4_readback #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regs      (regs),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_all    (rd_all),
        .rd_busy   (rd_busy),
        .rd_done   (rd_done),
        .rd_err    (rd_err),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int ready_mode = 0;

    // Reference model: the bits still owed for the current frame.
    bit exp_bit_q[$];
    bit exp_last_q[$];
    bit exp_bnd_q[$];
    bit active = 1'b0;
    bit exp_err = 1'b0;
    int gap_need = 0;

    // Raw observations of the DUT.
    bit cap_bit_q[$];
    bit cap_last_q[$];
    int done_total = 0, err_total = 0, gap_total = 0;
    int accept_cyc = 0, first_vld_cyc = 0, last_xfer_cyc = 0, done_cyc = 0;
    bit seen_vld = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] exp_pack(input logic [3:0] v);
        if (BPR == 5) return {27'b0, ^v, v};
        return {28'b0, v};
    endfunction

    function automatic logic [31:0] pack_bits(input int base, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++)
            if (base + i < cap_bit_q.size()) r[i] = cap_bit_q[base + i];
        return r;
    endfunction

    function automatic logic [31:0] pack_last(input int base, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++)
            if (base + i < cap_last_q.size()) r[i] = cap_last_q[base + i];
        return r;
    endfunction

    // Builds the expected bit list for a request seen on the inputs right now.
    task automatic build_frame();
        logic [3:0] v;
        int first, lastr;
        exp_bit_q.delete(); exp_last_q.delete(); exp_bnd_q.delete();
        if (rd_all) begin
            first = 0; lastr = NUM_REGS - 1; exp_err = 1'b0;
        end else begin
            first = int'(rd_addr); lastr = int'(rd_addr); exp_err = (int'(rd_addr) >= NUM_REGS);
        end
        for (int r = first; r <= lastr; r++) begin
            v = 4'h0;
            if (r < NUM_REGS) v = regs[4*r +: 4];
            for (int b = 0; b < BPR; b++) begin
                if (b < 4) exp_bit_q.push_back(v[b]);
                else       exp_bit_q.push_back(^v);
                exp_last_q.push_back(r == lastr && b == BPR - 1);
                exp_bnd_q.push_back(r != lastr && b == BPR - 1);
            end
        end
        gap_need = 1;
        active = 1'b1;
        accept_cyc = cyc;
        seen_vld = 1'b0;
    endtask

    task automatic monitor_loop();
        bit was_active, b, l, bd;
        forever begin
            @(negedge clk);
            cyc++;
            if (rd_done) begin done_total++; done_cyc = cyc; end
            if (rd_err) err_total++;
            if (rd_busy && !ser_valid && !rd_done) gap_total++;
            if (ser_valid && !seen_vld) begin seen_vld = 1'b1; first_vld_cyc = cyc; end
            if (ser_valid && ser_ready) begin
                cap_bit_q.push_back(ser_data);
                cap_last_q.push_back(ser_last);
                last_xfer_cyc = cyc;
            end
            if (!rst_n) begin
                check("rst_valid", ser_valid, 0);
                check("rst_busy", rd_busy, 0);
                check("rst_done", rd_done, 0);
                check("rst_err", rd_err, 0);
                check("rst_data", ser_data, 0);
                check("rst_last", ser_last, 0);
                active = 1'b0; gap_need = 0;
                exp_bit_q.delete(); exp_last_q.delete(); exp_bnd_q.delete();
            end else begin
                was_active = active;
                if (!active) begin
                    check("idle_valid", ser_valid, 0);
                    check("idle_busy", rd_busy, 0);
                    check("idle_done", rd_done, 0);
                    check("idle_err", rd_err, 0);
                    check("idle_last", ser_last, 0);
                end else if (gap_need > 0) begin
                    check("load_valid", ser_valid, 0);
                    check("load_busy", rd_busy, 1);
                    check("load_done", rd_done, 0);
                    check("load_last", ser_last, 0);
                    gap_need--;
                end else if (exp_bit_q.size() > 0) begin
                    b = exp_bit_q[0]; l = exp_last_q[0]; bd = exp_bnd_q[0];
                    check("shift_valid", ser_valid, 1);
                    check("shift_busy", rd_busy, 1);
                    check("shift_done", rd_done, 0);
                    check("ser_data", ser_data, b);
                    check("ser_last", ser_last, l);
                    if (ser_ready) begin
                        void'(exp_bit_q.pop_front());
                        void'(exp_last_q.pop_front());
                        void'(exp_bnd_q.pop_front());
                        if (bd) gap_need = 1;
                    end
                end else begin
                    check("done_pulse", rd_done, 1);
                    check("done_err", rd_err, exp_err);
                    check("done_valid", ser_valid, 0);
                    check("done_busy", rd_busy, 1);
                    active = 1'b0;
                end
                if (!was_active && (rd_all || rd_req)) build_frame();
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        rd_req = 1'b0;
        rd_all = 1'b0;
        case (ready_mode)
            0:       ser_ready = 1'b1;
            1:       ser_ready = (cyc % 3 == 0);
            default: ser_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic request(input bit all, input bit req, input logic [ADDR_W-1:0] addr);
        tick();
        rd_all = all;
        rd_req = req;
        rd_addr = addr;
    endtask

    task automatic wait_idle(input bit spur);
        int n = 0;
        tick();
        while (active && n < 400) begin
            if (spur && $urandom_range(0, 3) == 0) begin
                rd_req = 1'b1;
                rd_addr = ADDR_W'($urandom);
            end
            tick();
            n++;
        end
        check("frame_timeout", active, 0);
    endtask

    initial begin
        int base, d0, e0, g0;
        fork
            monitor_loop();
        join_none

        tick(); tick();
        check("reset_busy", rd_busy, 0);
        check("reset_valid", ser_valid, 0);
        rst_n = 1'b1;
        tick();

        // Single read of reg2 = 0xA.
        regs = 20'h00A00;
        base = cap_bit_q.size(); d0 = done_total; e0 = err_total;
        request(0, 1, 3'd2);
        wait_idle(0);
        check("s1_bits", pack_bits(base, BPR), S1_BITS);
        check("s1_last", pack_last(base, BPR), 32'(1) << (BPR - 1));
        check("s1_done_cnt", done_total - d0, 1);
        check("s1_err_cnt", err_total - e0, 0);
        check("s1_done_lat", done_cyc - last_xfer_cyc, 1);
        check("s1_first_lat", first_vld_cyc - accept_cyc, 2);

        // Whole-bank read.
        regs = 20'h54321;
        base = cap_bit_q.size(); d0 = done_total; g0 = gap_total;
        request(1, 0, 3'd0);
        wait_idle(0);
        check("s2_bits", pack_bits(base, NUM_REGS * BPR), S2_BITS);
        check("s2_last", pack_last(base, NUM_REGS * BPR), 32'(1) << (NUM_REGS * BPR - 1));
        check("s2_done_cnt", done_total - d0, 1);
        check("s2_load_cycles", gap_total - g0, NUM_REGS);

        // Stalled single read.
        ready_mode = 1;
        regs = 20'h00A00;
        base = cap_bit_q.size();
        request(0, 1, 3'd2);
        wait_idle(0);
        check("s3_bits", pack_bits(base, BPR), S1_BITS);
        ready_mode = 0;

        // Out-of-range address.
        regs = 20'hFFFFF;
        base = cap_bit_q.size(); d0 = done_total; e0 = err_total;
        request(0, 1, 3'd5);
        wait_idle(0);
        check("s4_bits", pack_bits(base, BPR), 32'h0);
        check("s4_done_cnt", done_total - d0, 1);
        check("s4_err_cnt", err_total - e0, 1);

        // Reset after the second bit of a bank read.
        regs = 20'h54321;
        base = cap_bit_q.size(); d0 = done_total;
        request(1, 0, 3'd0);
        begin
            int n = 0;
            tick();
            while (cap_bit_q.size() < base + 2 && n < 50) begin tick(); n++; end
            check("s5_reach_bit2", 32'(cap_bit_q.size() - base), 2);
        end
        rst_n = 1'b0;
        #1;
        check("s5_rst_valid", ser_valid, 0);
        check("s5_rst_busy", rd_busy, 0);
        check("s5_rst_last", ser_last, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("s5_no_done", done_total - d0, 0);
        base = cap_bit_q.size();
        request(0, 1, 3'd1);
        wait_idle(0);
        check("s5_after_bits", pack_bits(base, BPR), exp_pack(4'h2));

        // rd_req and rd_all together, plus requests while busy.
        regs = 20'h00007;
        base = cap_bit_q.size(); d0 = done_total;
        request(1, 1, 3'd3);
        wait_idle(1);
        check("s6_nbits", 32'(cap_bit_q.size() - base), NUM_REGS * BPR);
        check("s6_reg0", pack_bits(base, BPR), exp_pack(4'h7));
        check("s6_done_cnt", done_total - d0, 1);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int mode;
            regs = 20'($urandom);
            ready_mode = $urandom_range(0, 2);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       request(0, 1, ADDR_W'($urandom_range(0, NUM_REGS - 1)));
                1:       request(0, 1, ADDR_W'($urandom));
                2:       request(1, 0, 3'd0);
                default: request(1, 1, ADDR_W'($urandom));
            endcase
            wait_idle(1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        ready_mode = 0;
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
